// File: rtl/lp805x_syncg_cmdexec_pkg.sv
// Shared definitions for the lp805x_syncg command executor: opcodes, status codes,
// command/response field positions and FSM state encodings.
package lp805x_syncg_cmdexec_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [1:0] STS_OK      = 2'b00;
  localparam logic [1:0] STS_TIMEOUT = 2'b01;
  localparam logic [1:0] STS_BADOP   = 2'b10;

  localparam int unsigned OP_MSB   = 39;
  localparam int unsigned OP_LSB   = 38;
  localparam int unsigned TAG_MSB  = 37;
  localparam int unsigned TAG_LSB  = 32;
  localparam int unsigned ADDR_MSB = 31;
  localparam int unsigned ADDR_LSB = 16;
  localparam int unsigned DAT_MSB  = 15;
  localparam int unsigned DAT_LSB  = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAPT = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  function automatic logic [39:0] mk_resp(input logic [1:0]  status,
                                          input logic [5:0]  tag,
                                          input logic [15:0] addr,
                                          input logic [7:0]  data);
    return {status, tag, addr, data, 8'h00};
  endfunction

endpackage

// File: rtl/lp805x_syncg_cmdexec.sv
// Gateway command executor: pops a command word, performs one byte access on the local
// bus, and pushes a response word into the return gateway.
module lp805x_syncg_cmdexec
  import lp805x_syncg_cmdexec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 40,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TO_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rrdy,
  output logic                  rget,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  output logic                  bus_wr,
  output logic                  bus_rd,
  input  logic [7:0]            bus_rdata,
  input  logic                  bus_ack,
  output logic                  wput,
  input  logic                  wrdy,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  busy
);

  // cnt_q counts completed EXEC cycles; the cycle that takes it to all-ones is the last.
  localparam logic [TO_WIDTH-1:0] TO_LAST = {{(TO_WIDTH-1){1'b1}}, 1'b0};

  logic [1:0]            state_q, state_d;
  logic [5:0]            tag_q, tag_d;
  logic [15:0]           addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
  logic                  wr_q, wr_d, rd_q, rd_d, wput_q, wput_d;
  logic [DATA_WIDTH-1:0] resp_q, resp_d;
  logic [1:0]            cap_op;
  logic                  unused_rdata;

  assign cap_op       = rdata[OP_MSB:OP_LSB];
  assign unused_rdata = ^rdata[7:0];

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    wput_d  = wput_q;
    resp_d  = resp_q;
    case (state_q)
      S_IDLE: begin
        if (rrdy) state_d = S_CAPT;
      end
      S_CAPT: begin
        tag_d   = rdata[TAG_MSB:TAG_LSB];
        addr_d  = rdata[ADDR_MSB:ADDR_LSB];
        wdata_d = rdata[DAT_MSB:DAT_LSB];
        cnt_d   = '0;
        case (cap_op)
          OP_NOP: state_d = S_IDLE;
          OP_WR: begin
            wr_d    = 1'b1;
            state_d = S_EXEC;
          end
          OP_RD: begin
            rd_d    = 1'b1;
            state_d = S_EXEC;
          end
          default: begin
            resp_d  = DATA_WIDTH'(mk_resp(STS_BADOP, rdata[TAG_MSB:TAG_LSB],
                                          rdata[ADDR_MSB:ADDR_LSB], 8'h00));
            wput_d  = 1'b1;
            state_d = S_RESP;
          end
        endcase
      end
      S_EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_ack) begin
          resp_d  = DATA_WIDTH'(mk_resp(STS_OK, tag_q, addr_q, rd_q ? bus_rdata : 8'h00));
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          wput_d  = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          resp_d  = DATA_WIDTH'(mk_resp(STS_TIMEOUT, tag_q, addr_q, 8'h00));
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          wput_d  = 1'b1;
          state_d = S_RESP;
        end
      end
      default: begin
        if (wrdy) begin
          wput_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      wput_q  <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      wput_q  <= wput_d;
      resp_q  <= resp_d;
    end
  end

  // Gate with rst so a pop request never escapes while the gateway is being reset.
  assign rget      = (state_q == S_IDLE) & rrdy & ~rst;
  assign busy      = (state_q != S_IDLE);
  assign bus_addr  = ADDR_WIDTH'(addr_q);
  assign bus_wdata = wdata_q;
  assign bus_wr    = wr_q;
  assign bus_rd    = rd_q;
  assign wput      = wput_q;
  assign resp_data = resp_q;

endmodule

// File: tb/tb_lp805x_syncg_cmdexec.sv
// Self-checking bench for lp805x_syncg_cmdexec: directed scenarios plus randomized
// commands checked against a transaction-level response model.
module tb_lp805x_syncg_cmdexec;

  localparam int TOW    = 4;
  localparam int TO_CYC = 15;  // EXEC cycles before timeout with TO_WIDTH=4

  logic        clk = 1'b0;
  logic        rst;
  logic        rrdy;
  logic        rget;
  logic [39:0] rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_wr;
  logic        bus_rd;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic        wput;
  logic        wrdy;
  logic [39:0] resp_data;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  lp805x_syncg_cmdexec #(
    .DATA_WIDTH(40),
    .ADDR_WIDTH(16),
    .TO_WIDTH  (TOW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rrdy     (rrdy),
    .rget     (rget),
    .rdata    (rdata),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_wr   (bus_wr),
    .bus_rd   (bus_rd),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack),
    .wput     (wput),
    .wrdy     (wrdy),
    .resp_data(resp_data),
    .busy     (busy)
  );

  // Expected response word from the command and the EXEC cycle (1-based) where ack arrives.
  function automatic logic [39:0] model_resp(input logic [39:0] cmd, input int ack_at,
                                             input logic [7:0] rdv);
    logic [1:0] op;
    op = cmd[39:38];
    if (op == 2'b11) return {2'b10, cmd[37:16], 16'h0000};
    if (ack_at >= 1 && ack_at <= TO_CYC)
      return {2'b00, cmd[37:16], (op == 2'b10) ? rdv : 8'h00, 8'h00};
    return {2'b01, cmd[37:16], 16'h0000};
  endfunction

  function automatic logic [39:0] mk_cmd(input logic [1:0] op, input logic [5:0] tag,
                                         input logic [15:0] addr, input logic [7:0] wd);
    return {op, tag, addr, wd, 8'($urandom)};
  endfunction

  // One complete transaction, starting from IDLE at a negedge, ending in IDLE.
  task automatic run_cmd(input logic [39:0] cmd, input int ack_at, input logic [7:0] rdv,
                         input int wrdy_wait);
    logic [1:0]  op;
    logic [39:0] exp;
    int          limit;
    op  = cmd[39:38];
    exp = model_resp(cmd, ack_at, rdv);
    @(negedge clk);
    rrdy = 1'b1; wrdy = 1'($urandom); bus_ack = 1'($urandom);
    #1;
    n_total++;
    if (rget !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_pop: rget=%b busy=%b, want rget=1 busy=0", rget, busy);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    rrdy = 1'b0; rdata = cmd; bus_ack = 1'($urandom); wrdy = 1'($urandom);
    n_total++;
    if ({busy, rget, bus_wr, bus_rd, wput} !== 5'b10000)
      $display("FAIL capt_state: busy,rget,wr,rd,wput=%b want 10000",
               {busy, rget, bus_wr, bus_rd, wput});
    else n_pass++;
    @(posedge clk); @(negedge clk);
    rdata = {8'($urandom), 32'($urandom)};
    if (op == 2'b00) begin
      n_total++;
      if ({busy, bus_wr, bus_rd, wput} !== 4'b0000)
        $display("FAIL nop_idle: busy,wr,rd,wput=%b want 0000", {busy, bus_wr, bus_rd, wput});
      else n_pass++;
      bus_ack = 1'b0; wrdy = 1'b0;
      return;
    end
    if (op != 2'b11) begin
      limit = (ack_at >= 1 && ack_at <= TO_CYC) ? ack_at : TO_CYC;
      for (int n = 1; n <= limit; n++) begin
        n_total++;
        if (bus_wr !== (op == 2'b01) || bus_rd !== (op == 2'b10) || wput !== 1'b0 ||
            busy !== 1'b1)
          $display("FAIL exec_strobe cyc %0d: wr=%b rd=%b wput=%b busy=%b, want wr=%b rd=%b 0 1",
                   n, bus_wr, bus_rd, wput, busy, op == 2'b01, op == 2'b10);
        else n_pass++;
        n_total++;
        if (bus_addr !== cmd[31:16] || bus_wdata !== cmd[15:8])
          $display("FAIL exec_bus cyc %0d: addr=%h wdata=%h want %h %h",
                   n, bus_addr, bus_wdata, cmd[31:16], cmd[15:8]);
        else n_pass++;
        bus_ack   = (n == ack_at);
        bus_rdata = (n == ack_at) ? rdv : 8'($urandom);
        wrdy      = 1'($urandom);
        @(posedge clk); @(negedge clk);
      end
      bus_ack = 1'b0;
    end
    n_total++;
    if ({bus_wr, bus_rd, wput, busy} !== 4'b0011)
      $display("FAIL resp_entry: wr,rd,wput,busy=%b want 0011", {bus_wr, bus_rd, wput, busy});
    else n_pass++;
    for (int w = 0; w < wrdy_wait; w++) begin
      wrdy = 1'b0; rrdy = 1'b1; bus_ack = 1'($urandom);
      #1;
      n_total++;
      if (wput !== 1'b1 || resp_data !== exp || rget !== 1'b0 || bus_rd !== 1'b0 ||
          bus_wr !== 1'b0)
        $display("FAIL resp_stall %0d: wput=%b resp=%h rget=%b want 1 %h 0",
                 w, wput, resp_data, rget, exp);
      else n_pass++;
      @(posedge clk); @(negedge clk);
    end
    wrdy = 1'b1; rrdy = 1'b0; bus_ack = 1'($urandom);
    n_total++;
    if (wput !== 1'b1 || resp_data !== exp)
      $display("FAIL resp_word: wput=%b resp=%h want 1 %h", wput, resp_data, exp);
    else n_pass++;
    @(posedge clk); @(negedge clk);
    wrdy = 1'b0; bus_ack = 1'b0;
    n_total++;
    if (wput !== 1'b0 || busy !== 1'b0)
      $display("FAIL resp_done: wput=%b busy=%b want 0 0", wput, busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; rrdy = 1'b1; wrdy = 1'b1; bus_ack = 1'b1; bus_rdata = 8'hFF;
    rdata = 40'hFF_FFFF_FFFF;
    repeat (2) @(negedge clk);
    n_total++;
    if ({rget, bus_wr, bus_rd, wput, busy} !== 5'b0 || resp_data !== 40'h0 ||
        bus_addr !== 16'h0 || bus_wdata !== 8'h0)
      $display("FAIL reset_outputs: rget,wr,rd,wput,busy=%b resp=%h addr=%h wd=%h want all 0",
               {rget, bus_wr, bus_rd, wput, busy}, resp_data, bus_addr, bus_wdata);
    else n_pass++;
    rrdy = 1'b0; wrdy = 1'b0; bus_ack = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_rd_basic();
    run_cmd(mk_cmd(2'b10, 6'd5, 16'h1234, 8'h00), 3, 8'hA5, 0);
  endtask

  task automatic test_wr_zero_wait();
    run_cmd(mk_cmd(2'b01, 6'd9, 16'h00F0, 8'h3C), 1, 8'h77, 0);
  endtask

  task automatic test_timeout();
    run_cmd(mk_cmd(2'b10, 6'd17, 16'hBEEF, 8'h00), 0, 8'h00, 1);
  endtask

  task automatic test_ack_at_max();
    run_cmd(mk_cmd(2'b10, 6'd33, 16'h4321, 8'h00), TO_CYC, 8'h5A, 0);
    run_cmd(mk_cmd(2'b10, 6'd34, 16'h4322, 8'h00), TO_CYC + 1, 8'h5B, 0);
  endtask

  task automatic test_badop_nop();
    run_cmd(mk_cmd(2'b11, 6'd63, 16'hCAFE, 8'h12), 1, 8'h99, 0);
    run_cmd(mk_cmd(2'b00, 6'd1, 16'h0001, 8'h34), 1, 8'h99, 0);
  endtask

  task automatic test_wrdy_stall();
    run_cmd(mk_cmd(2'b01, 6'd42, 16'h8001, 8'hE7), 2, 8'h00, 10);
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk); rrdy = 1'b1;
    @(posedge clk); @(negedge clk); rrdy = 1'b0; rdata = mk_cmd(2'b10, 6'd3, 16'h0F0F, 8'h00);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    n_total++;
    if (bus_rd !== 1'b1) $display("FAIL pre_rst_rd: bus_rd=%b want 1", bus_rd);
    else n_pass++;
    rst = 1'b1; rrdy = 1'b1;
    #1;
    n_total++;
    if ({bus_rd, bus_wr, wput, rget, busy} !== 5'b0)
      $display("FAIL rst_mid_exec: rd,wr,wput,rget,busy=%b want 00000",
               {bus_rd, bus_wr, wput, rget, busy});
    else n_pass++;
    @(negedge clk); rst = 1'b0; rrdy = 1'b0;
    run_cmd(mk_cmd(2'b10, 6'd4, 16'h2468, 8'h00), 2, 8'hC3, 0);
  endtask

  task automatic test_back_to_back();
    run_cmd(mk_cmd(2'b01, 6'd10, 16'h1000, 8'h11), 1, 8'h00, 0);
    run_cmd(mk_cmd(2'b10, 6'd11, 16'h1001, 8'h00), 1, 8'h22, 0);
    run_cmd(mk_cmd(2'b11, 6'd12, 16'h1002, 8'h33), 1, 8'h00, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      run_cmd(mk_cmd(2'($urandom), 6'($urandom), 16'($urandom), 8'($urandom)),
              int'($urandom_range(0, 17)), 8'($urandom), int'($urandom_range(0, 3)));
  endtask

  initial begin
    rst = 1'b1; rrdy = 1'b0; wrdy = 1'b0; bus_ack = 1'b0; bus_rdata = 8'h00; rdata = '0;
    test_reset();
    test_rd_basic();
    test_wr_zero_wait();
    test_timeout();
    test_ack_at_max();
    test_badop_nop();
    test_wrdy_stall();
    test_reset_mid_exec();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
